stream_demux16b2: RTL and testbench
===================================

STREAM_DEMUX16B2 -- requirements
Module: stream_demux16b2

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data path width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH, word to be steered.
REQ-005 SHALL have port in_sel, input, 1, destination select: 0 = port A, 1 = port B.
REQ-006 SHALL have port in_valid, input, 1, in_data/in_sel valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts the word this cycle.
REQ-008 SHALL have ports a_data (output, WIDTH), a_valid (output, 1) and a_ready (input, 1), port A stream.
REQ-009 SHALL have ports b_data (output, WIDTH), b_valid (output, 1) and b_ready (input, 1), port B stream.
REQ-010 SHALL have ports a_cnt and b_cnt, output, 8 each, delivered-word counters (see Configuration).

Function
REQ-011 SHALL transfer on input when in_valid && in_ready at a rising edge; SHALL transfer on port X when X_valid && X_ready.
REQ-012 SHALL hold one output register per port, each with state EMPTY or FULL.
REQ-013 SHALL set in_ready = 1 iff the register selected by in_sel is EMPTY or is FULL and transferring out this cycle.
REQ-014 SHALL let in_ready depend combinationally on in_sel and the selected X_ready only, never on in_valid.
REQ-015 SHALL latch an accepted word into the selected register; X_valid rises the next cycle (latency 1).
REQ-016 SHALL move a register EMPTY->FULL on input accept with empty register; FULL->EMPTY on output transfer with no accept; stay FULL, reloading data, on simultaneous output transfer and accept.
REQ-017 SHALL drive X_valid = 1 iff register X is FULL; X_data = stored word, held stable while X_valid && !X_ready.
REQ-018 SHALL leave the unselected register unaffected by input activity; A and B drain independently.
REQ-019 SHALL stall input (in_ready = 0) while the selected register is FULL and not draining, even if the other register is EMPTY.
REQ-020 SHALL deliver words per port in acceptance order; no duplication, no loss.
REQ-021 SHALL drive X_data = 0 while register X is EMPTY.

Reset
REQ-022 SHALL, on rst_n low, immediately force both registers EMPTY, a_valid = b_valid = 0, a_data = b_data = 0 and a_cnt = b_cnt = 0, independent of clk.
REQ-023 SHALL discard words in flight at reset assertion; nothing is re-delivered after release.
REQ-024 SHALL accept input on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro STREAM_DEMUX16B2_CNT_EN to compile the counters in or out.
REQ-026 SHALL, with the macro defined, increment X_cnt by 1 on each port-X output transfer, wrapping 255 -> 0.
REQ-027 SHALL, with the macro undefined, tie a_cnt and b_cnt to 0 and synthesize no counter logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: reset, then in_data=16'h0000, in_sel=0, a_ready=1 -> a_valid=1, a_data=16'h0000 one cycle later; b_valid stays 0.
REQ-029 SHALL cover: in_data=16'hFFFF, in_sel=1, b_ready=0 -> b_valid=1 held with b_data=16'hFFFF; a second sel=1 word sees in_ready=0; a sel=0 word is accepted.
REQ-030 SHALL cover: port A FULL, a_ready=1, new sel=0 word 16'h1234 in the same cycle -> in_ready=1; next cycle a_data=16'h1234, a_valid=1.
REQ-031 SHALL cover: select toggled 0,1,0,1... for 10 words alternating 16'h0000/16'hFFFF, both readies 1 -> A receives only 16'h0000, B only 16'hFFFF, in order.
REQ-032 SHALL cover: rst_n pulsed low mid-clock with both registers FULL -> a_valid=b_valid=0 immediately, counters 0.
REQ-033 SHALL cover, with STREAM_DEMUX16B2_CNT_EN: 256 port-A transfers -> a_cnt returns to 0; b_cnt=0; without the macro both counters read 0.

Source files
------------

// File: rtl/stream_demux16b2.sv
// rtl/stream_demux16b2.sv - one-to-two stream demultiplexer with a single output register per port
// Optional delivered-word counters are compiled in by defining STREAM_DEMUX16B2_CNT_EN.
module stream_demux16b2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [7:0]       a_cnt,
    output logic [7:0]       b_cnt
);

    logic a_full;
    logic b_full;
    logic a_go;
    logic b_go;
    logic a_take;
    logic b_take;

    assign a_go = a_full && a_ready;
    assign b_go = b_full && b_ready;

    // Only the selected register gates the input; the other one never stalls it.
    assign in_ready = in_sel ? (!b_full || b_ready) : (!a_full || a_ready);

    assign a_take = in_valid && in_ready && !in_sel;
    assign b_take = in_valid && in_ready && in_sel;

    assign a_valid = a_full;
    assign b_valid = b_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full <= 1'b0;
            a_data <= '0;
        end else if (a_take) begin
            a_full <= 1'b1;
            a_data <= in_data;
        end else if (a_go) begin
            a_full <= 1'b0;
            a_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_full <= 1'b0;
            b_data <= '0;
        end else if (b_take) begin
            b_full <= 1'b1;
            b_data <= in_data;
        end else if (b_go) begin
            b_full <= 1'b0;
            b_data <= '0;
        end
    end

`ifdef STREAM_DEMUX16B2_CNT_EN
    // Counters wrap naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 8'd0;
            b_cnt <= 8'd0;
        end else begin
            if (a_go) a_cnt <= a_cnt + 8'd1;
            if (b_go) b_cnt <= b_cnt + 8'd1;
        end
    end
`else
    assign a_cnt = 8'd0;
    assign b_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_stream_demux16b2.sv
// tb/tb_stream_demux16b2.sv - directed self-checking bench for stream_demux16b2
module tb_stream_demux16b2;

`ifdef STREAM_DEMUX16B2_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  a_cnt;
    logic [7:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    stream_demux16b2 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic check_outputs(input string tag, input logic av, input logic [15:0] ad,
                                 input logic bv, input logic [15:0] bd);
        check({tag, " a_valid"}, {31'd0, a_valid}, {31'd0, av});
        check({tag, " a_data"},  {16'd0, a_data},  {16'd0, ad});
        check({tag, " b_valid"}, {31'd0, b_valid}, {31'd0, bv});
        check({tag, " b_data"},  {16'd0, b_data},  {16'd0, bd});
    endtask

    initial begin
        rst_n   = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        #1;
        check_outputs("reset", 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("reset a_cnt", {24'd0, a_cnt}, 32'd0);
        check("reset b_cnt", {24'd0, b_cnt}, 32'd0);
        tick();
        tick();

        // Basic steer to A, accepted on the first edge after release.
        rst_n   = 1'b1;
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0000);
        #1;
        check("first in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_outputs("a0000", 1'b1, 16'h0000, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check_outputs("a drain", 1'b0, 16'h0000, 1'b0, 16'h0000);

        // B fills and stalls; A still accepts.
        b_ready = 1'b0;
        drive(1'b1, 1'b1, 16'hFFFF);
        tick();
        check_outputs("bffff", 1'b0, 16'h0000, 1'b1, 16'hFFFF);
        drive(1'b1, 1'b1, 16'h5555);
        #1;
        check("b stall in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_outputs("b held", 1'b0, 16'h0000, 1'b1, 16'hFFFF);
        drive(1'b0, 1'b1, 16'h5555);
        #1;
        check("in_ready no valid", {31'd0, in_ready}, 32'd0);
        b_ready = 1'b1;
        #1;
        check("in_ready b_ready", {31'd0, in_ready}, 32'd1);
        b_ready = 1'b0;
        a_ready = 1'b0;
        drive(1'b1, 1'b0, 16'hAAAA);
        #1;
        check("a while b full", {31'd0, in_ready}, 32'd1);
        tick();
        check_outputs("aaaaa", 1'b1, 16'hAAAA, 1'b1, 16'hFFFF);

        // Full A drains and reloads in the same cycle.
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        #1;
        check("reload in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_outputs("a1234", 1'b1, 16'h1234, 1'b1, 16'hFFFF);
        b_ready = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check_outputs("both drain", 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Alternating selects with both ports ready.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i[0], i[0] ? 16'hFFFF : 16'h0000);
            tick();
            if (i[0])
                check_outputs("alt b", 1'b0, 16'h0000, 1'b1, 16'hFFFF);
            else
                check_outputs("alt a", 1'b1, 16'h0000, 1'b0, 16'h0000);
        end
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check_outputs("alt drain", 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Fill both, then reset asynchronously mid-cycle.
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h1111);
        tick();
        drive(1'b1, 1'b1, 16'h2222);
        tick();
        check_outputs("both full", 1'b1, 16'h1111, 1'b1, 16'h2222);
        drive(1'b0, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async reset", 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("async a_cnt", {24'd0, a_cnt}, 32'd0);
        check("async b_cnt", {24'd0, b_cnt}, 32'd0);
        tick();
        rst_n   = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        check_outputs("no redelivery", 1'b0, 16'h0000, 1'b0, 16'h0000);

        // 256 back-to-back A words; counter reaches 255 then wraps to 0.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            tick();
            check("burst a_data", {16'd0, a_data}, 32'(i));
        end
        check("a_cnt 255", {24'd0, a_cnt}, CNT_EN ? 32'd255 : 32'd0);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        check("a_cnt wrap", {24'd0, a_cnt}, 32'd0);
        check("b_cnt idle", {24'd0, b_cnt}, 32'd0);
        check("burst empty", {31'd0, a_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
